// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO: constant log2 and parameter legality checks.
package sync_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int span = 1; span < value; span = span * 2) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit fifo_params_ok(input int depth, input int afull_lvl, input int aempty_lvl);
        return is_pow2(depth) && (depth >= 4) && (depth <= 4096) &&
               (aempty_lvl < afull_lvl) && (afull_lvl <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one read port with a registered output.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn_in,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO control: wrap-bit pointers, registered fill level and status flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = clog2(DEPTH) + 1,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                 clk,
    input  logic                 rstn_in,
    input  logic                 write_in,
    input  logic [WIDTH-1:0]     data_write_in,
    input  logic                 read_in,
    output logic [WIDTH-1:0]     data_read_out,
    output logic                 valid_out,
    output logic                 full_out,
    output logic                 empty_out,
    output logic                 almost_full_out,
    output logic                 almost_empty_out,
    output logic [PTR_WIDTH-1:0] count_out,
    output logic                 overflow_out,
    output logic                 underflow_out
);

    localparam int ADDR_WIDTH = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] AFULL_CNT  = PTR_WIDTH'(AFULL_LVL);
    localparam logic [PTR_WIDTH-1:0] AEMPTY_CNT = PTR_WIDTH'(AEMPTY_LVL);

    if (!fifo_params_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
        $error("sync_fifo: illegal DEPTH / AFULL_LVL / AEMPTY_LVL combination");
    end

    logic [PTR_WIDTH-1:0] wptr, rptr;
    logic [PTR_WIDTH-1:0] wptr_nxt, rptr_nxt, count_nxt;
    logic                 wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO rejects a write even alongside a read.
    assign wr_acc = write_in && !full_out;
    assign rd_acc = read_in && !empty_out;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        if (wr_acc) wptr_nxt = wptr + 1'b1;
        if (rd_acc) rptr_nxt = rptr + 1'b1;
        count_nxt = wptr_nxt - rptr_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            wptr             <= '0;
            rptr             <= '0;
            count_out        <= '0;
            valid_out        <= 1'b0;
            full_out         <= 1'b0;
            empty_out        <= 1'b1;
            almost_full_out  <= 1'b0;
            almost_empty_out <= 1'b1;
            overflow_out     <= 1'b0;
            underflow_out    <= 1'b0;
        end else begin
            wptr             <= wptr_nxt;
            rptr             <= rptr_nxt;
            count_out        <= count_nxt;
            valid_out        <= rd_acc;
            full_out         <= (wptr_nxt[PTR_WIDTH-1] != rptr_nxt[PTR_WIDTH-1]) &&
                                (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
            empty_out        <= (wptr_nxt == rptr_nxt);
            almost_full_out  <= (count_nxt >= AFULL_CNT);
            almost_empty_out <= (count_nxt <= AEMPTY_CNT);
            overflow_out     <= write_in && full_out;
            underflow_out    <= read_in && empty_out;
        end
    end

    sync_fifo_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .rstn_in    (rstn_in),
        .write_en   (wr_acc),
        .write_addr (wptr[ADDR_WIDTH-1:0]),
        .write_data (data_write_in),
        .read_en    (rd_acc),
        .read_addr  (rptr[ADDR_WIDTH-1:0]),
        .read_data  (data_read_out)
    );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries; legal values are powers of two, 4 to 4096.
REQ-003 The block SHALL have parameter PTR_WIDTH, default log2(DEPTH)+1, pointer width including the wrap bit.
REQ-004 The block SHALL have parameter AFULL_LVL, default DEPTH-2, fill level at or above which almost_full_out asserts.
REQ-005 The block SHALL have parameter AEMPTY_LVL, default 2, fill level at or below which almost_empty_out asserts.
REQ-006 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- rstn_in, in, 1, reset; asynchronous, active-low.
- write_in, in, 1, write request.
- data_write_in, in, WIDTH, write data.
- read_in, in, 1, read request.
- data_read_out, out, WIDTH, registered read data.
- valid_out, out, 1, data_read_out holds a freshly popped word this cycle.
- full_out, out, 1, fill level equals DEPTH.
- empty_out, out, 1, fill level equals 0.
- almost_full_out, out, 1, fill level >= AFULL_LVL.
- almost_empty_out, out, 1, fill level <= AEMPTY_LVL.
- count_out, out, PTR_WIDTH, current fill level, 0 to DEPTH.
- overflow_out, out, 1, one-cycle pulse when a write is rejected.
- underflow_out, out, 1, one-cycle pulse when a read is rejected.

Function
REQ-007 Write acceptance SHALL be defined as write_in and not full_out, sampled at the edge; an accepted write stores data_write_in at wptr[PTR_WIDTH-2:0] and then increments wptr.
REQ-008 Read acceptance SHALL be defined as read_in and not empty_out; an accepted read registers mem[rptr[PTR_WIDTH-2:0]] into data_read_out and then increments rptr.
REQ-009 Read latency SHALL be 1 cycle: data_read_out and valid_out=1 appear in the cycle after the accepting edge; valid_out=0 otherwise; data_read_out holds its value when no read is accepted.
REQ-010 Pointers SHALL wrap modulo 2^PTR_WIDTH; full SHALL mean the MSBs differ and the low bits are equal; empty SHALL mean wptr equals rptr.
REQ-011 count_out SHALL equal wptr minus rptr, modulo 2^PTR_WIDTH.
REQ-012 All flags and count_out SHALL be registered outputs that reflect the state after the most recent edge, with no combinational path from the inputs.
REQ-013 A simultaneous accepted read and write SHALL leave count_out unchanged and advance both pointers.
REQ-014 When full, a write SHALL be rejected even if a read is accepted in the same cycle; that read is accepted and count_out drops by 1.
REQ-015 When empty, a read SHALL be rejected even if a write is accepted in the same cycle; that write is accepted and count_out rises by 1.
REQ-016 A rejected write or read SHALL pulse overflow_out or underflow_out respectively for exactly one cycle and SHALL NOT change any pointer or memory entry.
REQ-017 An accepted write SHALL first be readable in the cycle after the write edge, so empty_out deasserts one cycle after the write edge.

Reset
REQ-018 Assertion of rstn_in=0 SHALL immediately and asynchronously clear wptr, rptr, count_out, data_read_out, valid_out, full_out, overflow_out and underflow_out to 0, and set empty_out=1 and almost_empty_out=1.
REQ-019 almost_full_out SHALL be 0 in reset.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Deassertion of reset SHALL be synchronised by the integrator; the first accepted operation is at the first rising edge with rstn_in=1.
REQ-022 A reset mid-operation SHALL discard all stored words.

Structure
REQ-023 A shared package/header sync_fifo_pkg SHALL hold the clog2 function and the parameter legality checks (DEPTH a power of two; AEMPTY_LVL < AFULL_LVL <= DEPTH).
REQ-024 The storage SHALL be a sub-module, sync_fifo_ram: a 1-write/1-read, WIDTH x DEPTH, registered-read RAM; the control logic (pointers, flags, count) SHALL live in sync_fifo.

Verification
REQ-025 Reset, then write 16 words 0x00..0x0F with no reads -> full_out=1, count_out=16, almost_full_out from count 14; a 17th write -> overflow_out pulses once and count stays 16.
REQ-026 From full, read 16 times -> data_read_out 0x00..0x0F, each with valid_out=1 one cycle after the read; empty_out=1 after the last; one more read -> underflow_out pulse and valid_out=0.
REQ-027 Run 40 writes and reads in lockstep at count 5 -> count_out stays 5, pointers wrap twice, data stays in order.
REQ-028 Full plus simultaneous write and read -> read accepted, write rejected with overflow_out=1, count_out=15.
REQ-029 Empty plus simultaneous write and read -> underflow_out=1, count_out=1, and the written word is readable next cycle.
REQ-030 Assert rstn_in low mid-cycle at count 9 -> outputs clear with no clock edge; after release, empty_out=1 and the first read underflows.
